// File: rtl/layer_out_serializer.sv
// layer_out_serializer: captures one layer's neuron outputs and streams them one word per cycle to the next layer
module layer_out_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [numNeurons*dataWidth-1:0] in_data,
  input  logic [numNeurons-1:0]           in_valid,
  input  logic                            clr_err,
  output logic [dataWidth-1:0]            out_data,
  output logic                            out_valid,
  output logic                            frame_done,
  output logic                            busy,
  output logic                            overrun,
  output logic                            misalign
);
  localparam int CW = $clog2(numNeurons);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t                          state;
  logic [CW-1:0]                   cnt;
  logic [numNeurons*dataWidth-1:0] hold;
  logic                            all_v;
  logic                            part_v;
  logic                            last;
  assign all_v  = &in_valid;
  assign part_v = |in_valid & ~all_v;
  assign last   = (state == SHIFT) && (cnt == CW'(numNeurons - 1));
  // Output stage runs one word behind the counter, so a frame arriving on the last-count cycle chains with no gap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hold       <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      misalign   <= 1'b0;
    end else begin
      out_valid  <= state == SHIFT;
      busy       <= state == SHIFT;
      frame_done <= last;
      if (state == SHIFT) out_data <= hold[cnt*dataWidth +: dataWidth];
      if (all_v && (state == IDLE || last)) begin
        hold  <= in_data;
        cnt   <= '0;
        state <= SHIFT;
      end else if (state == SHIFT) begin
        cnt <= cnt + CW'(1);
        if (last) state <= IDLE;
      end
      overrun  <= (all_v && state == SHIFT && !last) | (overrun & ~clr_err);
      misalign <= part_v | (misalign & ~clr_err);
    end
  end
endmodule

// File: tb/tb_layer_out_serializer.sv
// tb_layer_out_serializer: randomized and directed check of layer_out_serializer against a frame-schedule model
module tb_layer_out_serializer;
  localparam int NN = 4;
  localparam int DW = 16;
  logic              clk = 1'b0;
  logic              rst;
  logic [NN*DW-1:0]  in_data;
  logic [NN-1:0]     in_valid;
  logic              clr_err;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              frame_done;
  logic              busy;
  logic              overrun;
  logic              misalign;

  layer_out_serializer #(.numNeurons(NN), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .clr_err(clr_err),
    .out_data(out_data), .out_valid(out_valid), .frame_done(frame_done), .busy(busy),
    .overrun(overrun), .misalign(misalign)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [DW-1:0] fa[NN];
  logic [DW-1:0] fb[NN];
  int          ta = 0;
  int          tb_ = 0;
  bit          ha = 0;
  bit          hb = 0;
  logic [DW-1:0] e_data;
  bit          e_ovr;
  bit          e_mis;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    ha = 0;
    hb = 0;
    e_data = '0;
    e_ovr = 0;
    e_mis = 0;
  endtask

  // A frame accepted at edge t owns output cycles t+1..t+NN; the newest and the previous frame cover chaining
  task automatic check_outs();
    bit v = 0;
    bit fd = 0;
    if (ha && cyc > ta && cyc <= ta + NN) begin
      v = 1; e_data = fa[cyc-ta-1]; fd = (cyc == ta + NN);
    end else if (hb && cyc > tb_ && cyc <= tb_ + NN) begin
      v = 1; e_data = fb[cyc-tb_-1]; fd = (cyc == tb_ + NN);
    end
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("busy", 32'(busy), 32'(v));
    chk("out_data", 32'(out_data), 32'(e_data));
    chk("frame_done", 32'(frame_done), 32'(fd));
    chk("overrun", 32'(overrun), 32'(e_ovr));
    chk("misalign", 32'(misalign), 32'(e_mis));
  endtask

  task automatic step(input logic [NN-1:0] v, input logic [NN*DW-1:0] d, input logic c);
    bit all_v, part_v, acc;
    in_valid = v;
    in_data = d;
    clr_err = c;
    @(posedge clk);
    cyc++;
    all_v = (v == '1);
    part_v = (v != '0) && !all_v;
    acc = all_v && (!ha || cyc >= ta + NN);
    if (acc) begin
      fb = fa; tb_ = ta; hb = ha;
      for (int i = 0; i < NN; i++) fa[i] = d[i*DW +: DW];
      ta = cyc; ha = 1;
    end
    e_ovr = (all_v && !acc) | (e_ovr & !c);
    e_mis = part_v | (e_mis & !c);
    @(negedge clk);
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0, '0, 1'b0);
  endtask

  function automatic logic [NN*DW-1:0] pk(input logic [DW-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  function automatic logic [NN*DW-1:0] rnd_data();
    logic [NN*DW-1:0] r;
    for (int i = 0; i < NN; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    clr_err = 1'b0;
    model_reset();
    @(negedge clk);
    check_outs();
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    step('1, pk(16'h0001, 16'h0002, 16'h0003, 16'h0004), 1'b0);
    idle(6);
    step('1, pk(16'h0001, 16'h0002, 16'h0003, 16'h0004), 1'b0);
    idle(3);
    step('1, pk(16'h00D1, 16'h00D2, 16'h00D3, 16'h00D4), 1'b0);
    idle(6);
    step('1, pk(16'h0011, 16'h0022, 16'h0033, 16'h0044), 1'b0);
    idle(1);
    step('1, pk(16'hBAD1, 16'hBAD2, 16'hBAD3, 16'hBAD4), 1'b0);
    idle(4);
    step('0, '0, 1'b1);
    idle(2);
    step(4'b0101, rnd_data(), 1'b0);
    idle(2);
    step(4'b0010, '0, 1'b1);
    step('0, '0, 1'b1);
    idle(1);
    step('1, pk(16'hA001, 16'hA002, 16'hA003, 16'hA004), 1'b0);
    idle(2);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_frame_done", 32'(frame_done), 32'd0);
    model_reset();
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_outs();
    end
    rst = 1'b0;
    idle(6);
    for (int i = 0; i < 500; i++) begin
      int r;
      logic [NN-1:0] v;
      r = int'($urandom_range(0, 29));
      v = (r < 5) ? '1 : (r < 8) ? NN'($urandom_range(1, (1 << NN) - 2)) : '0;
      step(v, rnd_data(), ($urandom_range(0, 7) == 0));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
